// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : cpu_ctrl_pkg                                               |
// | Purpose : Shared CPU / UART-programmer control types. Holds the FSM  |
// |           state encoding, the width of the state_dbg LED bus and the |
// |           per-state output table.                                    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package cpu_ctrl_pkg;

  localparam int C_STATE_W = 3;

  typedef enum logic [C_STATE_W-1:0] {
    ST_LOCK_WAIT = 3'd0,
    ST_RESTART   = 3'd1,
    ST_RUN       = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_PROG      = 3'd4
  } state_e;

  typedef struct packed {
    logic cpu_rst;
    logic upg_rst;
    logic upg_en;
  } ctrl_out_t;

  // Output levels for each state; unused encodings fall back to the
  // safe LOCK_WAIT levels (CPU and programmer both held in reset).
  function automatic ctrl_out_t state_outs(input state_e st);
    ctrl_out_t o;
    case (st)
      ST_RUN:   o = '{cpu_rst: 1'b0, upg_rst: 1'b1, upg_en: 1'b0};
      ST_PROG:  o = '{cpu_rst: 1'b1, upg_rst: 1'b0, upg_en: 1'b1};
      default:  o = '{cpu_rst: 1'b1, upg_rst: 1'b1, upg_en: 1'b0};
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : btn_debounce                                               |
// | Purpose : Synchronizes a raw push-button and accepts a new level only|
// |           after DB_CYCLES consecutive identical samples. Emits a     |
// |           one-cycle press pulse on each accepted 0->1 change.        |
// | Ports   : clk    - clock                                             |
// |           rst    - asynchronous active-high reset                    |
// |           btn_in - raw, bouncy button input (async to clk)           |
// |           level  - debounced button level                            |
// |           press  - 1-cycle pulse on debounced rising edge            |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module btn_debounce #(
  parameter int DB_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic press
);

  localparam int C_CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DB_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_level;
  logic               r_press;
  logic [C_CNT_W-1:0] r_cnt;

  logic w_diff;
  logic w_accept;

  // The count tracks how many consecutive samples disagree with the
  // accepted level; a sample matching the level breaks the run.
  assign w_diff   = (r_sync2 != r_level);
  assign w_accept = w_diff && (r_cnt == C_CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= r_sync2;
        r_press <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/upg_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : upg_mode_ctrl                                              |
// | Purpose : Sequences CPU reset and UART-programming mode. Waits for   |
// |           PLL lock, holds the CPU in reset for RST_CYCLES, runs it,  |
// |           and on a debounced button press drains the CPU for         |
// |           DRAIN_CYCLES before handing the memories to the programmer |
// |           until upg_done.                                            |
// | Ports   : clk        - clock (UART-programming clock)                |
// |           rst        - asynchronous active-high reset                |
// |           pll_locked - PLL lock, async to clk                        |
// |           btn_mode   - raw programming-request button                |
// |           upg_done   - programmer finished (level or pulse)          |
// |           cpu_rst    - CPU core reset, active high                   |
// |           upg_rst    - UART programmer reset, active high            |
// |           upg_en     - memories owned by the programmer              |
// |           state_dbg  - current FSM state encoding                    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module upg_mode_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DB_CYCLES    = 20,
  parameter int DRAIN_CYCLES = 4,
  parameter int RST_CYCLES   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pll_locked,
  input  logic                 btn_mode,
  input  logic                 upg_done,
  output logic                 cpu_rst,
  output logic                 upg_rst,
  output logic                 upg_en,
  output logic [C_STATE_W-1:0] state_dbg
);

  localparam int C_CNT_MAX = (DRAIN_CYCLES > RST_CYCLES) ? DRAIN_CYCLES : RST_CYCLES;
  localparam int C_CNT_W   = (C_CNT_MAX < 2) ? 1 : $clog2(C_CNT_MAX + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_SAT   = '1;
  localparam logic [C_CNT_W-1:0] C_RST_LAST  = C_CNT_W'(RST_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_DRN_LAST  = C_CNT_W'(DRAIN_CYCLES - 1);

  logic               r_lock_s1;
  logic               r_lock_s;
  state_e             r_state;
  logic [C_CNT_W-1:0] r_cnt;
  logic               r_cpu_rst;
  logic               r_upg_rst;
  logic               r_upg_en;

  state_e             w_state_nxt;
  ctrl_out_t          w_outs_nxt;
  logic               w_btn_level;
  logic               w_btn_press;
  logic               w_press;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_mode),
    .level  (w_btn_level),
    .press  (w_btn_press)
  );

  // Pulse and level are updated on the same edge, so this qualification
  // never removes a genuine press; it only ties the pulse to a high level.
  assign w_press = w_btn_press & w_btn_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock_s1 <= 1'b0;
      r_lock_s  <= 1'b0;
    end else begin
      r_lock_s1 <= pll_locked;
      r_lock_s  <= r_lock_s1;
    end
  end

  // Next state and next outputs. Outputs are derived from the next state
  // and registered so they change on the same edge as the state itself.
  always_comb begin
    w_state_nxt = r_state;
    if (!r_lock_s) begin
      // Loss of lock beats every other transition.
      w_state_nxt = ST_LOCK_WAIT;
    end else begin
      case (r_state)
        ST_LOCK_WAIT: w_state_nxt = ST_RESTART;
        ST_RESTART:   if (r_cnt == C_RST_LAST) w_state_nxt = ST_RUN;
        ST_RUN:       if (w_press)             w_state_nxt = ST_DRAIN;
        ST_DRAIN:     if (r_cnt == C_DRN_LAST) w_state_nxt = ST_PROG;
        ST_PROG:      if (upg_done)            w_state_nxt = ST_RESTART;
        default:      w_state_nxt = ST_LOCK_WAIT;
      endcase
    end
    w_outs_nxt = state_outs(w_state_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_LOCK_WAIT;
      r_cnt     <= '0;
      r_cpu_rst <= 1'b1;
      r_upg_rst <= 1'b1;
      r_upg_en  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cpu_rst <= w_outs_nxt.cpu_rst;
      r_upg_rst <= w_outs_nxt.upg_rst;
      r_upg_en  <= w_outs_nxt.upg_en;
      // Cleared on any state change; saturates so long stays never wrap.
      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != C_CNT_SAT) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign cpu_rst   = r_cpu_rst;
  assign upg_rst   = r_upg_rst;
  assign upg_en    = r_upg_en;
  assign state_dbg = r_state;

endmodule
`default_nettype wire

// File: tb/tb_upg_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_upg_mode_ctrl                                           |
// | Purpose : Directed self-checking bench for upg_mode_ctrl: reset      |
// |           release, bouncy press into programming mode, upg_done      |
// |           return, lock loss, ignored inputs in DRAIN and an          |
// |           asynchronous reset glitch in PROG.                         |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_upg_mode_ctrl;

  localparam logic [2:0] S_LW = 3'd0;
  localparam logic [2:0] S_RS = 3'd1;
  localparam logic [2:0] S_RN = 3'd2;
  localparam logic [2:0] S_DR = 3'd3;
  localparam logic [2:0] S_PG = 3'd4;

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic       btn_mode;
  logic       upg_done;
  logic       cpu_rst;
  logic       upg_rst;
  logic       upg_en;
  logic [2:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  upg_mode_ctrl #(
    .DB_CYCLES    (20),
    .DRAIN_CYCLES (4),
    .RST_CYCLES   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .btn_mode   (btn_mode),
    .upg_done   (upg_done),
    .cpu_rst    (cpu_rst),
    .upg_rst    (upg_rst),
    .upg_en     (upg_en),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  // Expected {state, cpu_rst, upg_rst, upg_en} for a given state.
  function automatic logic [5:0] exp_outs(input logic [2:0] st);
    case (st)
      S_LW:    return {S_LW, 3'b110};
      S_RS:    return {S_RS, 3'b110};
      S_RN:    return {S_RN, 3'b010};
      S_DR:    return {S_DR, 3'b110};
      S_PG:    return {S_PG, 3'b101};
      default: return 6'h3f;
    endcase
  endfunction

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [2:0] st);
    tick();
    check(tag, {state_dbg, cpu_rst, upg_rst, upg_en}, exp_outs(st));
  endtask

  // Button high from now: RUN for 22 edges, DRAIN on 23, PROG on 27.
  task automatic press_to_prog(input string tag);
    btn_mode = 1'b1;
    for (int i = 1; i <= 27; i++) begin
      step($sformatf("%s_%0d", tag, i),
           (i < 23) ? S_RN : ((i < 27) ? S_DR : S_PG));
    end
  endtask

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b1;
    btn_mode   = 1'b0;
    upg_done   = 1'b0;
    #12;
    check("reset_vals", {state_dbg, cpu_rst, upg_rst, upg_en}, {S_LW, 3'b110});

    // Release reset just after an edge; lock sync 2, LOCK_WAIT 1, RESTART 8.
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      step($sformatf("boot_%0d", i), (i < 3) ? S_LW : ((i < 11) ? S_RS : S_RN));
    end

    // Bounce with 5-cycle phases, ending low; never long enough to accept.
    for (int p = 0; p < 12; p++) begin
      btn_mode = (p % 2 == 0);
      for (int c = 0; c < 5; c++) step($sformatf("bounce_%0d_%0d", p, c), S_RN);
    end
    press_to_prog("hold");

    // One-cycle upg_done: RESTART next edge, RUN 8 edges later.
    tick();
    step("prog_wait", S_PG);
    upg_done = 1'b1;
    step("done_edge", S_RS);
    upg_done = 1'b0;
    for (int i = 1; i <= 8; i++) step($sformatf("rst_after_done_%0d", i), (i < 8) ? S_RS : S_RN);
    for (int i = 0; i < 40; i++) step($sformatf("held_no_retrig_%0d", i), S_RN);

    // Release, then press again to get back into PROG.
    btn_mode = 1'b0;
    for (int i = 0; i < 30; i++) step($sformatf("release_a_%0d", i), S_RN);
    press_to_prog("press2");

    // Lock loss for 10 cycles in PROG; done during LOCK_WAIT is ignored.
    pll_locked = 1'b0;
    step("unlock_1", S_PG);
    step("unlock_2", S_PG);
    step("unlock_3", S_LW);
    upg_done = 1'b1;
    for (int i = 4; i <= 10; i++) step($sformatf("unlock_%0d", i), S_LW);
    upg_done   = 1'b0;
    pll_locked = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      step($sformatf("relock_%0d", i), (i < 3) ? S_LW : ((i < 11) ? S_RS : S_RN));
    end
    for (int i = 0; i < 5; i++) step($sformatf("relock_run_%0d", i), S_RN);

    // DRAIN with upg_done and a button change arriving: both ignored.
    btn_mode = 1'b0;
    for (int i = 0; i < 30; i++) step($sformatf("release_b_%0d", i), S_RN);
    btn_mode = 1'b1;
    for (int i = 1; i <= 23; i++) step($sformatf("press3_%0d", i), (i < 23) ? S_RN : S_DR);
    upg_done = 1'b1;
    btn_mode = 1'b0;
    for (int i = 24; i <= 26; i++) step($sformatf("drain_ign_%0d", i), S_DR);
    upg_done = 1'b0;
    step("drain_to_prog", S_PG);
    step("prog_stay_1", S_PG);
    step("prog_stay_2", S_PG);

    // 1 ns reset glitch mid-cycle in PROG: outputs reset with no edge.
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    check("glitch_rst", {state_dbg, cpu_rst, upg_rst, upg_en}, {S_LW, 3'b110});
    for (int i = 1; i <= 3; i++) step($sformatf("post_glitch_%0d", i), (i < 3) ? S_LW : S_RS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
